// File: rtl/spi_master_ctrl.sv
// SPI master: serialises {cmd, data} MSB-first behind a one-cycle lead and,
// for read-data frames, shifts ADDR_SIZE bits back in from MISO.
module spi_master_ctrl #(
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned TURNAROUND = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_cmd,
  input  logic [ADDR_SIZE-1:0] req_data,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int unsigned FrameW = ADDR_SIZE + 2;
  localparam int unsigned CntMax = (FrameW > TURNAROUND) ? FrameW : TURNAROUND;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  // Counters run down to zero; each load is (cycles in state - 1).
  localparam logic [CntW-1:0] CntTx   = CntW'(FrameW - 1);
  localparam logic [CntW-1:0] CntWait = CntW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
  localparam logic [CntW-1:0] CntRx   = CntW'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StTx,
    StWait,
    StRx,
    StStop
  } state_e;

  state_e               state;
  logic [FrameW-1:0]    frame;
  logic                 rd;
  logic [CntW-1:0]      cnt;
  logic [ADDR_SIZE-1:0] rx_shift;
  logic [ADDR_SIZE-1:0] rx_next;

  assign req_ready = (state == StIdle);
  assign busy      = ~req_ready;
  assign rx_next   = {rx_shift[ADDR_SIZE-2:0], MISO};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      frame     <= '0;
      rd        <= 1'b0;
      cnt       <= '0;
      rx_shift  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            frame <= {req_cmd, req_data};
            rd    <= (req_cmd == 2'b11);
            cnt   <= '0;
            SS_n  <= 1'b0;
            MOSI  <= 1'b0;
            state <= StStart;
          end
        end
        StStart: begin
          // MOSI is registered, so each bit is presented on the edge entering its cycle.
          MOSI  <= frame[FrameW-1];
          frame <= {frame[FrameW-2:0], 1'b0};
          cnt   <= CntTx;
          state <= StTx;
        end
        StTx: begin
          if (cnt != '0) begin
            MOSI  <= frame[FrameW-1];
            frame <= {frame[FrameW-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
          end else begin
            MOSI <= 1'b0;
            if (!rd) begin
              SS_n  <= 1'b1;
              cnt   <= '0;
              state <= StStop;
            end else if (TURNAROUND != 0) begin
              cnt   <= CntWait;
              state <= StWait;
            end else begin
              cnt   <= CntRx;
              state <= StRx;
            end
          end
        end
        StWait: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt   <= CntRx;
            state <= StRx;
          end
        end
        StRx: begin
          rx_shift <= rx_next;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Publish on entry so rsp_valid is high during the STOP cycle itself.
            rsp_data  <= rx_next;
            rsp_valid <= 1'b1;
            SS_n      <= 1'b1;
            cnt       <= '0;
            state     <= StStop;
          end
        end
        StStop: begin
          cnt   <= '0;
          state <= StIdle;
        end
        default: begin
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench: dut0 uses TURNAROUND=2, dut1 uses TURNAROUND=0.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst;
  logic [1:0]      req_valid;
  logic [1:0][1:0] req_cmd;
  logic [1:0][7:0] req_data;
  logic [1:0]      miso;
  logic [1:0][7:0] slave_byte;
  wire  [1:0]      req_ready;
  wire  [1:0]      rsp_valid;
  wire  [1:0][7:0] rsp_data;
  wire  [1:0]      busy;
  wire  [1:0]      ss_n;
  wire  [1:0]      mosi;

  spi_master_ctrl #(.ADDR_SIZE(8), .TURNAROUND(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_cmd(req_cmd[0]), .req_data(req_data[0]), .rsp_valid(rsp_valid[0]),
    .rsp_data(rsp_data[0]), .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
  );

  spi_master_ctrl #(.ADDR_SIZE(8), .TURNAROUND(0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_cmd(req_cmd[1]), .req_data(req_data[1]), .rsp_valid(rsp_valid[1]),
    .rsp_data(rsp_data[1]), .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
  );

  typedef struct {
    int          dut;
    int          len;
    logic [31:0] word;
    bit          valid;
    bit          chk_data;
    logic [7:0]  data;
    bit          abort;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input int d, input int len, input logic [31:0] word,
                              input bit valid, input bit chk_data, input logic [7:0] data,
                              input bit abort, input int gap);
    exp_t e;
    e.dut = d; e.len = len; e.word = word; e.valid = valid;
    e.chk_data = chk_data; e.data = data; e.abort = abort; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Returns #1 after the accepting edge; hold keeps req_valid asserted afterwards.
  task automatic send(input int d, input logic [1:0] cmd, input logic [7:0] data, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL req_ready timeout on dut%0d: got 0 required 1", d);
    end
    req_valid[d] = 1'b1;
    req_cmd[d]   = cmd;
    req_data[d]  = data;
    @(posedge clk);
    #1;
    if (!hold) req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || req_ready != 2'b11) && n < 500);
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: queue %0d entries, req_ready 0x%0h required 0x3",
               exp_q.size(), req_ready);
    end
    repeat (3) @(negedge clk);
  endtask

  // Slave model: drives slave_byte MSB-first during the RX window, 1 elsewhere.
  int sidx[2];
  initial begin
    int rx0;
    miso = 2'b11;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ss_n[d] !== 1'b0) begin
          sidx[d] = 0;
          miso[d] = 1'b1;
        end else begin
          rx0 = (d == 0) ? 13 : 11;
          if (sidx[d] >= rx0 && sidx[d] < rx0 + 8) miso[d] = slave_byte[d][7 - (sidx[d] - rx0)];
          else miso[d] = 1'b1;
          sidx[d]++;
        end
      end
    end
  end

  // Monitor: pops an expectation when SS_n falls, compares when SS_n rises.
  bit          in_frame[2];
  bit          ready_next[2];
  int          len[2];
  int          gap[2];
  logic [31:0] word[2];
  exp_t        cur[2];
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!in_frame[d] && ss_n[d] == 1'b0) begin
          in_frame[d] = 1'b1;
          len[d]      = 0;
          word[d]     = '0;
          if (exp_q.size() != 0 && exp_q[0].dut == d) begin
            cur[d] = exp_q.pop_front();
            if (cur[d].gap != 0) check("ss_n high gap", gap[d], cur[d].gap);
          end else begin
            checks++;
            errors++;
            $display("FAIL unexpected frame on dut%0d: got a frame required none", d);
            cur[d].dut = d; cur[d].len = 0; cur[d].word = '0; cur[d].valid = 1'b0;
            cur[d].chk_data = 1'b0; cur[d].data = '0; cur[d].abort = 1'b0; cur[d].gap = 0;
          end
        end
        if (in_frame[d]) begin
          if (ss_n[d] == 1'b0) begin
            len[d]++;
            word[d] = {word[d][30:0], mosi[d]};
            if (rsp_valid[d]) check("rsp_valid inside frame", rsp_valid[d], 0);
          end else begin
            in_frame[d] = 1'b0;
            check("frame length", len[d], cur[d].len);
            check("mosi bits", word[d], cur[d].word);
            check("rsp_valid at frame end", rsp_valid[d], cur[d].valid);
            if (cur[d].chk_data) check("rsp_data", rsp_data[d], cur[d].data);
            check("req_ready at frame end", req_ready[d], cur[d].abort);
            ready_next[d] = !cur[d].abort;
            gap[d]        = 1;
          end
        end else begin
          if (ready_next[d]) begin
            check("req_ready after stop", req_ready[d], 1);
            ready_next[d] = 1'b0;
          end
          if (rsp_valid[d]) check("rsp_valid outside frame", rsp_valid[d], 0);
          gap[d]++;
        end
      end
    end
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst        = 2'b11;
    req_valid  = 2'b00;
    req_cmd    = '0;
    req_data   = '0;
    slave_byte = '0;
    repeat (2) @(posedge clk);
    #1 rst = 2'b00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset SS_n", ss_n[d], 1);
      check("reset MOSI", mosi[d], 0);
      check("reset rsp_valid", rsp_valid[d], 0);
      check("reset rsp_data", rsp_data[d], 8'h00);
      check("reset req_ready", req_ready[d], 1);
      check("reset busy", busy[d], 0);
    end
    mon_en = 1'b1;

    // Write address 0x3C
    expect_frame(0, 11, 32'h0003C, 1'b0, 1'b1, 8'h00, 1'b0, 0);
    send(0, 2'b00, 8'h3C, 1'b0);
    drain();

    // Read data, slave returns 0xA5
    slave_byte[0] = 8'hA5;
    expect_frame(0, 21, 32'hE5800, 1'b1, 1'b1, 8'hA5, 1'b0, 0);
    send(0, 2'b11, 8'h96, 1'b0);
    drain();

    // Back-to-back with request changed mid-frame
    expect_frame(0, 11, 32'h0017E, 1'b0, 1'b1, 8'hA5, 1'b0, 0);
    send(0, 2'b01, 8'h7E, 1'b1);
    repeat (3) @(negedge clk);
    req_cmd[0]  = 2'b10;
    req_data[0] = 8'h81;
    expect_frame(0, 11, 32'h00281, 1'b0, 1'b1, 8'hA5, 1'b0, 2);
    send(0, 2'b10, 8'h81, 1'b0);
    drain();

    // Reset during RX cycle 4 of a read-data frame
    slave_byte[0] = 8'hC3;
    expect_frame(0, 18, 32'h18000, 1'b0, 1'b1, 8'h00, 1'b1, 0);
    send(0, 2'b11, 8'h00, 1'b0);
    repeat (17) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    drain();

    // Clean read after the abort
    slave_byte[0] = 8'h3C;
    expect_frame(0, 21, 32'hFFC00, 1'b1, 1'b1, 8'h3C, 1'b0, 0);
    send(0, 2'b11, 8'hFF, 1'b0);
    drain();

    // TURNAROUND=0 build, slave returns 0x5A
    slave_byte[1] = 8'h5A;
    expect_frame(1, 19, 32'h30000, 1'b1, 1'b1, 8'h5A, 1'b0, 0);
    send(1, 2'b11, 8'h00, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
